// File: rtl/logic_unit_pkg.sv
// Shared opcode constants and result-flag helper for the logic unit family.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_ANDN  = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  // Widest result the flag helper handles; callers zero-extend into it.
  localparam int FLAG_W = 64;

  typedef struct packed {
    logic zero;
    logic ones;
    logic parity;
  } flags_t;

  // y holds a w-bit value zero-extended to FLAG_W bits.
  function automatic flags_t calc_flags(input logic [FLAG_W-1:0] y, input int w);
    logic [FLAG_W-1:0] mask;
    flags_t f;
    mask     = {FLAG_W{1'b1}} >> (FLAG_W - w);
    f.zero   = (y == '0);
    f.ones   = ((~y & mask) == '0);
    f.parity = ^y;
    return f;
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Producer/consumer bus of the pipelined logic unit, with the unit as slave.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] tx_count;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, acc_clear, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity, acc_q, tx_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, acc_clear, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_ones, out_parity, acc_q, tx_count
  );

endinterface

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit bitwise logic core; reused unchanged by the ALU.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    y = '0;
    unique case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_ANDN:  y = a & ~b;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit: one-deep valid/ready output stage, accumulator
// operand, coherent reduction flags and a saturating accept counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  logic_unit_pipe_if.slave bus
);

  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  flags_t           flags;

  logic             valid_q;
  logic [WIDTH-1:0] y_q;
  flags_t           flags_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // The register frees up in the same cycle the consumer drains it.
  assign ready  = !valid_q || bus.out_ready;
  assign accept = bus.in_valid && ready;

  // Clear wins over the held accumulator only when selecting the operand.
  assign op_a = bus.in_acc ? (bus.acc_clear ? '0 : acc_q) : bus.in_a;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a  (op_a),
    .b  (bus.in_b),
    .op (bus.in_op),
    .y  (result)
  );

  assign flags = calc_flags(FLAG_W'(result), WIDTH);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      flags_q <= '{zero: 1'b1, ones: 1'b0, parity: 1'b0};
    end else if (accept) begin
      valid_q <= 1'b1;
      y_q     <= result;
      flags_q <= flags;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (accept && bus.in_acc) begin
      acc_q <= result;
    end else if (bus.acc_clear) begin
      acc_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_y      = y_q;
  assign bus.out_zero   = flags_q.zero;
  assign bus.out_ones   = flags_q.ones;
  assign bus.out_parity = flags_q.parity;
  assign bus.acc_q      = acc_q;
  assign bus.tx_count   = cnt_q;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the single-bit combinational AND: WIDTH-bit bitwise logic unit with eight selectable ops.
- Optional accumulator operand; one-deep output register with valid/ready handshake; reduction flags; saturating transaction counter.
- Sits between a stimulus/producer stage and any consumer in lab designs; first building block of the course ALU.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of transaction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a transaction.
- in_ready  out  1  unit can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  operation select.
- in_acc  in  1  1: use accumulator as operand A instead of in_a.
- acc_clear  in  1  synchronous accumulator clear.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes result.
- out_y  out  WIDTH  result.
- out_zero  out  1  out_y == 0.
- out_ones  out  1  out_y all ones.
- out_parity  out  1  XOR-reduction of out_y.
- acc_q  out  WIDTH  current accumulator value.
- tx_count  out  CNT_W  accepted transactions, saturating.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_y=0, out_zero=1, out_ones=0, out_parity=0, acc_q=0, tx_count=0. Reset mid-transfer drops the held result; no partial state survives.
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (A & ~B), 7 PASS_B. All bitwise, full WIDTH, no carries.
- Operand A = in_acc ? (acc_clear ? 0 : acc_q) : in_a.
- Accept = in_valid & in_ready.
- Handshake: in_ready = !out_valid | out_ready (combinational). Producer holds inputs stable while in_valid & !in_ready. Consumer sees out_* stable while out_valid & !out_ready.
- Latency: result registered; out_valid rises the cycle after accept. Full throughput (1/cycle) when out_ready is held high.
- Output register on clock edge:
  - Accept: load result and flags, out_valid=1.
  - Else if out_ready: out_valid=0; out_y keeps its last value.
- Flags are computed from the result before registering, so they are always coherent with out_y.
- Accumulator:
  - On accept with in_acc=1, acc_q <= result.
  - Else if acc_clear, acc_q <= 0.
  - Accept with in_acc=1 and acc_clear=1 uses 0 as A, and acc_q <= result. Clear has priority on the operand only.
  - Accept with in_acc=0 does not alter acc_q, unless acc_clear=1, in which case acc_q <= 0.
- tx_count: increments on each accept. Holds at 2^CNT_W-1 (no wrap). Only rst clears it.
- Backpressure: out_valid=1 & out_ready=0 forces in_ready=0. Simultaneous drain and accept (out_ready=1) replaces the result in the same edge with no bubble.

Decomposition:
- Package logic_unit_pkg:
  - op localparams OP_AND..OP_PASSB (3-bit).
  - function for the reduction flags.
- One sub-module, logic_unit_core: purely combinational (a, b, op -> y), parametrised on WIDTH. Reused later by the ALU.
- Handshake register, accumulator and counter stay in logic_unit_pipe.

Test Plan:
- Reset then idle: assert rst 3 cycles mid-simulation after a pending result -> out_valid=0, out_y=0, out_zero=1, acc_q=0, tx_count=0 immediately (async), before next clock.
- Op sweep, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC, ops 0..7 on consecutive cycles -> out_y = C0, FC, 3C, 3F, 03, C3, 30, CC, one per cycle, starting the cycle after first accept; out_parity=0 for all; tx_count=8.
- Flags: a=8'hFF, b=8'hFF, AND -> out_y=FF, out_ones=1, out_zero=0. XOR -> out_y=00, out_zero=1. a=8'h01, b=8'h00, OR -> out_parity=1.
- Accumulate: acc_clear with first accept, in_acc=1, OR with b=01, 02, 04, 80 -> out_y 01, 03, 07, 87; acc_q=8'h87. Then in_acc=0, AND a=0F, b=FF -> out_y=0F, acc_q stays 87.
- Backpressure: out_ready=0 for 4 cycles after a result -> in_ready=0, out_y stable, no second accept. Release with in_valid held -> drain and new accept on the same edge, no bubble cycle.
- Saturation, CNT_W=4: 20 back-to-back accepts -> tx_count reaches 15 and holds.
